// File: rtl/icache_pkg.sv
// Shared icache refill definitions: line geometry, refill FSM states and the
// helper that forms a word-aligned read address inside a line.
package icache_pkg;

  localparam int TAG_W          = 22;
  localparam int IDX_W          = 5;
  localparam int OFF_W          = 5;
  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_W         = 32;
  localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BURST,
    DRAIN,
    RESP
  } refill_state_e;

  function automatic logic [31:0] word_addr(input logic [31:OFF_W] line,
                                            input logic [WSEL_W-1:0] word);
    return {line, word, 2'b00};
  endfunction

endpackage

// File: rtl/icache_refill_resp_line_buf.sv
// Eight-word line buffer for the refill engine: one slot written per cycle,
// whole line presented in parallel, cleared on reset or at the start of a fill.
module refill_line_buf
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [WSEL_W-1:0]     slot_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [LINE_W-1:0]     line_o
);

  logic [WORD_W-1:0] mem_q [WORDS_PER_LINE];

  // NOTE: this storage is reset deliberately; an abandoned fill must not leave
  // old words visible on the response bus, so it cannot be a plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[slot_i] <= wdata_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) line_o[i*WORD_W +: WORD_W] = mem_q[i];
  end

endmodule

// File: rtl/icache_refill_resp.sv
// Icache line refill engine: accepts a miss, bursts 8 word reads to memory and
// returns the filled line. Define ICACHE_REFILL_CWF_EN for critical-word-first.
module icache_refill_resp
  import icache_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_in,
  input  logic [31:0]        req_addr_in,
  output logic               req_ready_out,
  output logic               mem_rd_en_out,
  output logic [31:0]        mem_addr_out,
  input  logic [31:0]        mem_rdata_in,
  output logic               resp_valid_out,
  input  logic               resp_ready_in,
  output logic [LINE_W-1:0]  resp_data_out,
  output logic [TAG_W-1:0]   resp_tag_out,
  output logic [IDX_W-1:0]   resp_idx_out
);

  localparam logic [3:0] WAIT_INIT = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

  refill_state_e     state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [WSEL_W-1:0] beat_q, beat_d;
  logic [31:2]       addr_q, addr_d;
  logic              wr_pend_q;
  logic [WSEL_W-1:0] wr_slot_q;
  logic [WSEL_W-1:0] issue_word;
  logic              accept;
  logic              unused_bits;

`ifdef ICACHE_REFILL_CWF_EN
  assign issue_word = addr_q[4:2] + beat_q;
`else
  assign issue_word = beat_q;
`endif

  assign unused_bits  = ^{req_addr_in[1:0], addr_q[4:2]};
  assign resp_tag_out = addr_q[31:10];
  assign resp_idx_out = addr_q[9:5];

  // NOTE: every signal driven here gets its default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    beat_d         = beat_q;
    addr_d         = addr_q;
    accept         = 1'b0;
    req_ready_out  = 1'b0;
    mem_rd_en_out  = 1'b0;
    mem_addr_out   = '0;
    resp_valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
          accept  = 1'b1;
          addr_d  = req_addr_in[31:2];
          beat_d  = '0;
          wait_d  = WAIT_INIT;
          state_d = (MEM_LATENCY == 0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) state_d = BURST;
        else                wait_d  = wait_q - 4'd1;
      end
      BURST: begin
        mem_rd_en_out = 1'b1;
        mem_addr_out  = word_addr(addr_q[31:5], issue_word);
        beat_d        = beat_q + 3'd1;
        if (beat_q == 3'(WORDS_PER_LINE - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = RESP;
      RESP: begin
        resp_valid_out = 1'b1;
        if (resp_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      wr_pend_q <= 1'b0;
      wr_slot_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      // Read data returns one cycle after the strobe, so remember its slot.
      wr_pend_q <= mem_rd_en_out;
      wr_slot_q <= issue_word;
    end
  end

  refill_line_buf u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept),
    .we_i    (wr_pend_q),
    .slot_i  (wr_slot_q),
    .wdata_i (mem_rdata_in),
    .line_o  (resp_data_out)
  );

endmodule

// File: tb/tb_icache_refill_resp.sv
// Directed bench for icache_refill_resp: latency 2 and latency 0 instances fed
// by a memory model whose read data equals the read address.
module tb_icache_refill_resp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic         req_valid = 1'b0, req_ready, rd_en, resp_valid, resp_ready = 1'b0;
  logic [31:0]  req_addr = '0, mem_addr, rdata;
  logic [255:0] resp_data;
  logic [21:0]  resp_tag;
  logic [4:0]   resp_idx;

  logic         zv = 1'b0, zr, zrd, zrv, zrr = 1'b0;
  logic [31:0]  za = '0, zma, zrdata;
  logic [255:0] zdata;
  logic [21:0]  ztag;
  logic [4:0]   zidx;

  icache_refill_resp #(.MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid_in(req_valid), .req_addr_in(req_addr),
    .req_ready_out(req_ready), .mem_rd_en_out(rd_en), .mem_addr_out(mem_addr),
    .mem_rdata_in(rdata), .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_data_out(resp_data), .resp_tag_out(resp_tag), .resp_idx_out(resp_idx)
  );

  icache_refill_resp #(.MEM_LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid_in(zv), .req_addr_in(za),
    .req_ready_out(zr), .mem_rd_en_out(zrd), .mem_addr_out(zma),
    .mem_rdata_in(zrdata), .resp_valid_out(zrv), .resp_ready_in(zrr),
    .resp_data_out(zdata), .resp_tag_out(ztag), .resp_idx_out(zidx)
  );

  // Memory model: data = address, one cycle after the strobe; junk otherwise.
  always @(posedge clk) begin
    rdata  <= rd_en ? mem_addr : 32'hDEAD_BEEF;
    zrdata <= zrd   ? zma      : 32'hBAD0_BAD0;
  end

  function automatic logic [31:0] exp_issue(input logic [31:0] a, input int k);
    logic [2:0] w;
    w = 3'(k);
`ifdef ICACHE_REFILL_CWF_EN
    w = a[4:2] + 3'(k);
`endif
    return {a[31:5], w, 2'b00};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = {a[31:5], 5'b0} + 32'(4 * k);
    return l;
  endfunction

  logic [31:0] iss_q [8];
  int          n_iss, first_iss, resp_cyc;

  // Called at a negedge; observes strobes until the response appears.
  task automatic collect();
    n_iss = 0; first_iss = -1; resp_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (rd_en) begin
        if (n_iss < 8) iss_q[n_iss] = mem_addr;
        if (first_iss < 0) first_iss = cyc;
        n_iss++;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept(input logic [31:0] a, output int e0);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout ready=%0b required=1", req_ready);
    end
    @(negedge clk);
    e0 = cyc;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rd_en, resp_valid} !== 3'b100 || mem_addr !== 32'h0 ||
        resp_data !== 256'h0 || resp_tag !== 22'h0 || resp_idx !== 5'h0) begin
      failures++;
      $display("FAIL reset_outputs ready/rd/valid=%b addr=%h tag=%h idx=%h required 100/0/0/0",
               {req_ready, rd_en, resp_valid}, mem_addr, resp_tag, resp_idx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_base_fill();
    int e0;
    accept(32'h0000_1234, e0);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    collect();
    checks++;
    if (first_iss !== e0 + 2) begin
      failures++;
      $display("FAIL base_first_issue cycle=%0d required=%0d", first_iss, e0 + 2);
    end
    checks++;
    if (n_iss !== 8) begin
      failures++;
      $display("FAIL base_issue_count got=%0d required=8", n_iss);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (iss_q[k] !== exp_issue(32'h0000_1234, k)) begin
        failures++;
        $display("FAIL base_issue_%0d addr=%h required=%h", k, iss_q[k], exp_issue(32'h0000_1234, k));
      end
    end
    checks++;
    if (resp_cyc !== e0 + 11) begin
      failures++;
      $display("FAIL base_resp_latency cycle=%0d required=%0d", resp_cyc, e0 + 11);
    end
    checks++;
    if (resp_data !== exp_line(32'h0000_1234)) begin
      failures++;
      $display("FAIL base_data got=%h required=%h", resp_data, exp_line(32'h0000_1234));
    end
    checks++;
    if (resp_tag !== 22'h000004 || resp_idx !== 5'h11 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL base_tag_idx tag=%h idx=%h ready=%b required 000004/11/0", resp_tag, resp_idx, req_ready);
    end
    handshake();
  endtask

  task automatic test_zero_latency();
    int e0, fz, rz, nz;
    fz = -1; rz = -1; nz = 0;
    zv = 1'b1;
    za = 32'h0000_1234;
    @(negedge clk);
    e0 = cyc;
    zv = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (zrd) begin
        if (fz < 0) begin
          fz = cyc;
          checks++;
          if (zma !== exp_issue(32'h0000_1234, 0)) begin
            failures++;
            $display("FAIL zero_first_addr addr=%h required=%h", zma, exp_issue(32'h0000_1234, 0));
          end
        end
        nz++;
      end
      if (zrv) begin
        rz = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (fz !== e0 || nz !== 8) begin
      failures++;
      $display("FAIL zero_first_issue cycle=%0d count=%0d required %0d/8", fz, nz, e0);
    end
    checks++;
    if (rz !== e0 + 9) begin
      failures++;
      $display("FAIL zero_resp_latency cycle=%0d required=%0d", rz, e0 + 9);
    end
    checks++;
    if (zdata !== exp_line(32'h0000_1234) || ztag !== 22'h000004 || zidx !== 5'h11) begin
      failures++;
      $display("FAIL zero_data got=%h tag=%h idx=%h", zdata, ztag, zidx);
    end
    zrr = 1'b1;
    @(negedge clk);
    zrr = 1'b0;
  endtask

  task automatic test_backpressure();
    int e0;
    accept(32'h0000_ABC8, e0);
    req_valid = 1'b0;
    collect();
    checks++;
    if (resp_cyc !== e0 + 11) begin
      failures++;
      $display("FAIL bp_resp_latency cycle=%0d required=%0d", resp_cyc, e0 + 11);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== exp_line(32'h0000_ABC8) ||
          resp_tag !== 22'h00002A || resp_idx !== 5'h1E) begin
        failures++;
        $display("FAIL bp_hold_%0d valid=%b ready=%b tag=%h idx=%h required 1/0/00002A/1E",
                 i, resp_valid, req_ready, resp_tag, resp_idx);
      end
    end
    handshake();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle_after ready=%b valid=%b required 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    int e0, seen;
    seen = 0;
    accept(32'h2000_0040, e0);
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_en) seen++;
      if (seen == 3) break;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (seen !== 3 || rd_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 ||
        mem_addr !== 32'h0 || resp_data !== 256'h0) begin
      failures++;
      $display("FAIL mid_reset seen=%0d rd=%b valid=%b ready=%b addr=%h required 3/0/0/1/0",
               seen, rd_en, resp_valid, req_ready, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    accept(32'h0000_5678, e0);
    req_valid = 1'b0;
    collect();
    checks++;
    if (resp_cyc !== e0 + 11 || resp_data !== exp_line(32'h0000_5678) ||
        resp_tag !== 22'h000015 || resp_idx !== 5'h13) begin
      failures++;
      $display("FAIL post_reset_fill cycle=%0d tag=%h idx=%h data=%h required %0d/000015/13",
               resp_cyc, resp_tag, resp_idx, resp_data, e0 + 11);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int e0, hs;
    accept(32'h0000_1000, e0);
    req_addr = 32'h0000_2FFC;
    collect();
    checks++;
    if (resp_data !== exp_line(32'h0000_1000) || resp_tag !== 22'h000004 || resp_idx !== 5'h00) begin
      failures++;
      $display("FAIL b2b_first data=%h tag=%h idx=%h", resp_data, resp_tag, resp_idx);
    end
    handshake();
    hs = cyc;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle ready=%b valid=%b required 1/0", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept ready=%b required=0", req_ready);
    end
    collect();
    checks++;
    if (first_iss !== hs + 3 || resp_cyc !== hs + 12) begin
      failures++;
      $display("FAIL b2b_second_timing issue=%0d resp=%0d required %0d/%0d",
               first_iss, resp_cyc, hs + 3, hs + 12);
    end
    checks++;
    if (resp_data !== exp_line(32'h0000_2FFC) || resp_tag !== 22'h00000B || resp_idx !== 5'h1F) begin
      failures++;
      $display("FAIL b2b_second_data data=%h tag=%h idx=%h", resp_data, resp_tag, resp_idx);
    end
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_base_fill();
    test_zero_latency();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_refill_resp.md
ICACHE_REFILL_RESP -- requirements
Module: icache_refill_resp

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning wait cycles between request acceptance and the first memory read issue (legal range 0..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_in, input, 1, line-fill request valid from the icache controller.
REQ-005 SHALL have port req_addr_in, input, 32, miss byte address.
REQ-006 SHALL have port req_ready_out, output, 1, request accepted when high together with req_valid_in.
REQ-007 SHALL have port mem_rd_en_out, output, 1, word read strobe to backing memory.
REQ-008 SHALL have port mem_addr_out, output, 32, word-aligned read byte address.
REQ-009 SHALL have port mem_rdata_in, input, 32, read data, valid exactly 1 cycle after mem_rd_en_out.
REQ-010 SHALL have port resp_valid_out, output, 1, filled line available.
REQ-011 SHALL have port resp_ready_in, input, 1, controller consumes the line.
REQ-012 SHALL have port resp_data_out, output, 256, line data, word k at bits [32k+31:32k].
REQ-013 SHALL have port resp_tag_out, output, 22, tag = req_addr_in[31:10].
REQ-014 SHALL have port resp_idx_out, output, 5, set index = req_addr_in[9:5].

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, BURST, DRAIN, RESP.
REQ-016 SHALL drive req_ready_out high only in IDLE; the handshake latches the address and moves to WAIT, or to BURST when MEM_LATENCY=0.
REQ-017 SHALL stay in WAIT for exactly MEM_LATENCY cycles, counted by a down-counter, then enter BURST.
REQ-018 SHALL assert mem_rd_en_out for exactly 8 consecutive BURST cycles, issue k using mem_addr_out = {line_addr[31:5], word_k[2:0], 2'b00}, with word_k = k in default order.
REQ-019 SHALL write mem_rdata_in into the line-buffer slot of the word issued in the previous cycle; the eighth word is captured in DRAIN (1 cycle).
REQ-020 SHALL enter RESP after DRAIN; resp_valid_out rises at edge E0+MEM_LATENCY+9, where E0 is the request acceptance edge.
REQ-021 SHALL hold resp_valid_out, resp_data_out, resp_tag_out and resp_idx_out stable in RESP until resp_ready_in is high, then return to IDLE.
REQ-022 SHALL NOT accept a new request in the cycle of the response handshake; the earliest acceptance is the following cycle.
REQ-023 SHALL ignore req_addr_in[1:0]; req_addr_in changes after acceptance SHALL NOT affect the fill.
REQ-024 SHALL keep mem_rd_en_out low outside BURST and SHALL ignore mem_rdata_in outside BURST/DRAIN.
REQ-025 SHALL overwrite all 8 line-buffer slots on every fill; no stale data from a previous fill SHALL appear.

Reset
REQ-026 SHALL, on rst high at any time including mid-burst, immediately enter IDLE, abandon the fill, and clear the counters and line buffer.
REQ-027 SHALL drive the following reset output values: req_ready_out=1, mem_rd_en_out=0, mem_addr_out=0, resp_valid_out=0, resp_data_out=0, resp_tag_out=0, resp_idx_out=0.

Configuration
REQ-028 SHALL support macro ICACHE_REFILL_CWF_EN: when defined, the burst is critical-word-first with word_k = (req_addr_in[4:2]+k) mod 8.
REQ-029 SHALL, without ICACHE_REFILL_CWF_EN, issue words 0..7 in ascending order; resp_data_out content and latency are identical in both modes.

Structure
REQ-030 SHALL take from shared package icache_pkg: TAG_W=22, IDX_W=5, OFF_W=5, LINE_W=256, WORDS_PER_LINE=8, and the refill state enum.
REQ-031 SHALL place slot write and hold in sub-module refill_line_buf (8x32 storage, slot write enable, clear).

Verification
REQ-032 SHALL cover the base fill: MEM_LATENCY=2, req 0x0000_1234, mem word = address -> reads 0x1220..0x123C ascending; resp_valid at E0+11; tag 0x000004, idx 0x11; word k = 0x1220+4k.
REQ-033 SHALL cover zero latency: MEM_LATENCY=0 -> first mem_rd_en_out in cycle after E0; resp_valid at E0+9.
REQ-034 SHALL cover CWF order: ICACHE_REFILL_CWF_EN, req 0x0000_1234 -> read order 0x1234,0x1238,0x123C,0x1220..0x1230; resp_data identical to REQ-032.
REQ-035 SHALL cover backpressure: resp_ready_in low 5 cycles -> outputs stable, req_ready_out=0 throughout; IDLE one cycle after handshake.
REQ-036 SHALL cover reset mid-burst: rst pulse after issue 3 -> mem_rd_en_out=0 and resp_valid_out=0 immediately; next request fills correctly.
REQ-037 SHALL cover back-to-back requests: held req_valid_in with 2 addresses -> second accepted exactly one cycle after first response handshake.
